// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter
//   Shares one NoC send port between N_REQ requesters. Whole packets are
//   arbitrated round-robin: a granted head flit locks the port to that
//   requester until its tail flit has been accepted. A requester is only
//   eligible when its target VC reports non-full and that VC is not already
//   being written by the flit sitting in the output register.
//
// Parameters
//   N_REQ   number of requesters (2..8)
//   FLIT_W  flit width in bits
//
// Ports
//   clk                  clock, all state on rising edge
//   res                  asynchronous active-high reset
//   req_i                per-requester flit valid
//   flit_i               per-requester flit, requester k at [k*FLIT_W +: FLIT_W]
//   tail_i               per-requester last-flit-of-packet flag
//   vc_i                 per-requester target VC (0/1)
//   ack_o                one-hot accept, combinational
//   put_flit             registered flit to the NoC send port
//   en_put               registered put enable
//   en_get_non_full_VCs  VC status read enable (high while not in reset)
//   get_non_full_VCs     per-VC non-full flags from the NoC
//   busy_o               packet lock held
//   stall_cnt_o          (only with NOC_INJECT_STALL_CNT_EN) saturating count
//                        of cycles with a pending request but no accept
//
// Optional feature macro: NOC_INJECT_STALL_CNT_EN

module noc_inject_arbiter #(
    parameter int N_REQ  = 4,
    parameter int FLIT_W = 32
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*FLIT_W-1:0] flit_i,
    input  logic [N_REQ-1:0]        tail_i,
    input  logic [N_REQ-1:0]        vc_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic [FLIT_W-1:0]       put_flit,
    output logic                    en_put,
    output logic                    en_get_non_full_VCs,
    input  logic [1:0]              get_non_full_VCs,
    output logic                    busy_o
`ifdef NOC_INJECT_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt_o
`endif
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state, stateNext;
    logic [PTR_W-1:0] rrPtr, rrPtrNext;
    logic [PTR_W-1:0] lockId, lockIdNext;
    logic [PTR_W-1:0] winner;
    logic             accept;
    logic             vcQ;
    logic [N_REQ-1:0] eligible;

    // A VC can take a new flit only if it is non-full and the flit already in
    // the output register is not headed to the same VC (the NoC status lags
    // one cycle behind the put).
    always_comb begin
        eligible = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            eligible[k] = req_i[k] && get_non_full_VCs[vc_i[k]] &&
                          !(en_put && (vcQ == vc_i[k]));
        end
    end

    always_comb begin
        stateNext  = state;
        rrPtrNext  = rrPtr;
        lockIdNext = lockId;
        winner     = '0;
        accept     = 1'b0;
        ack_o      = '0;

        case (state)
            IDLE: begin
                // First eligible requester scanning upward from rrPtr.
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    int unsigned idx;
                    idx = (int'(rrPtr) + i) % N_REQ;
                    if (!accept && eligible[idx]) begin
                        accept = 1'b1;
                        winner = PTR_W'(idx);
                    end
                end
            end
            LOCKED: begin
                winner = lockId;
                accept = eligible[lockId];
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Reset forces acks low even though the arbitration inputs may be live.
        if (res) begin
            accept = 1'b0;
        end

        if (accept) begin
            ack_o[winner] = 1'b1;
            if (tail_i[winner]) begin
                stateNext = IDLE;
                rrPtrNext = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
            end else if (state == IDLE) begin
                stateNext  = LOCKED;
                lockIdNext = winner;
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state  <= IDLE;
            rrPtr  <= '0;
            lockId <= '0;
        end else begin
            state  <= stateNext;
            rrPtr  <= rrPtrNext;
            lockId <= lockIdNext;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            en_put   <= 1'b0;
            put_flit <= '0;
            vcQ      <= 1'b0;
        end else begin
            en_put <= accept;
            if (accept) begin
                put_flit <= flit_i[winner*FLIT_W +: FLIT_W];
                vcQ      <= vc_i[winner];
            end
        end
    end

    assign busy_o              = (state == LOCKED);
    assign en_get_non_full_VCs = ~res;

`ifdef NOC_INJECT_STALL_CNT_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            stallCnt <= '0;
        end else if ((|req_i) && (ack_o == '0) && (stallCnt != '1)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign stall_cnt_o = stallCnt;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter
//   Directed bench for noc_inject_arbiter (N_REQ=4, FLIT_W=32). Inputs are
//   driven 1 time unit after the rising edge, acks are sampled just before
//   the falling edge, and the registered put is checked 1 unit after the
//   following rising edge. Flits expected to be accepted are queued when
//   their ack is expected and popped when en_put must appear.

module tb_noc_inject_arbiter;

    logic        clk;
    logic        res;
    logic [3:0]  req;
    logic [3:0]  tail;
    logic [3:0]  vc;
    logic [3:0]  ack;
    logic [1:0]  nonFull;
    logic [31:0] fl [4];
    logic [127:0] flitBus;
    logic [31:0] putFlit;
    logic        enPut;
    logic        enGet;
    logic        busy;
`ifdef NOC_INJECT_STALL_CNT_EN
    logic [15:0] stallCnt;
    int unsigned expStall;
`endif

    int unsigned total;
    int unsigned passed;
    logic [31:0] sbQ[$];
    logic [31:0] lastFlit;

    always_comb flitBus = {fl[3], fl[2], fl[1], fl[0]};

    noc_inject_arbiter #(
        .N_REQ  (4),
        .FLIT_W (32)
    ) dut (
        .clk                 (clk),
        .res                 (res),
        .req_i               (req),
        .flit_i              (flitBus),
        .tail_i              (tail),
        .vc_i                (vc),
        .ack_o               (ack),
        .put_flit            (putFlit),
        .en_put              (enPut),
        .en_get_non_full_VCs (enGet),
        .get_non_full_VCs    (nonFull),
        .busy_o              (busy)
`ifdef NOC_INJECT_STALL_CNT_EN
        ,
        .stall_cnt_o         (stallCnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic int unsigned ohIdx(input logic [3:0] oh);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    // Called at posedge+1 with inputs already driven for this cycle.
    task automatic cyc(input logic [3:0] expAck, input logic expBusy, input string tag);
        logic [31:0] e;
        #3;
        chk({tag, " ack_o"}, 64'(ack), 64'(expAck));
        chk({tag, " busy_o"}, 64'(busy), 64'(expBusy));
        chk({tag, " en_get"}, 64'(enGet), 64'd1);
        if (expAck != 4'b0000) begin
            sbQ.push_back(fl[ohIdx(expAck)]);
        end
`ifdef NOC_INJECT_STALL_CNT_EN
        if ((req != 4'b0000) && (expAck == 4'b0000) && (expStall != 16'hFFFF)) expStall++;
`endif
        @(posedge clk);
        #1;
        if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            chk({tag, " en_put"}, 64'(enPut), 64'd1);
            chk({tag, " put_flit"}, 64'(putFlit), 64'(e));
            lastFlit = e;
        end else begin
            chk({tag, " en_put"}, 64'(enPut), 64'd0);
            chk({tag, " put_flit hold"}, 64'(putFlit), 64'(lastFlit));
        end
`ifdef NOC_INJECT_STALL_CNT_EN
        chk({tag, " stall_cnt"}, 64'(stallCnt), 64'(expStall));
`endif
    endtask

    initial begin
        logic [3:0] ord [4];
        total    = 0;
        passed   = 0;
        lastFlit = '0;
`ifdef NOC_INJECT_STALL_CNT_EN
        expStall = 0;
`endif
        res     = 1'b1;
        req     = 4'b0000;
        tail    = 4'b1111;
        vc      = 4'b0000;
        nonFull = 2'b11;
        fl[0] = 32'h1000_0000;
        fl[1] = 32'h1100_0000;
        fl[2] = 32'h1200_0000;
        fl[3] = 32'h1300_0000;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst ack_o", 64'(ack), 64'd0);
        chk("rst en_put", 64'(enPut), 64'd0);
        chk("rst put_flit", 64'(putFlit), 64'd0);
        chk("rst busy_o", 64'(busy), 64'd0);
        chk("rst en_get", 64'(enGet), 64'd0);
        res = 1'b0;

        // Two 1-flit streams on alternating VCs: 0,2,0,2 back to back
        req  = 4'b0101;
        vc   = 4'b0100;
        tail = 4'b1111;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                cyc(4'b0001, 1'b0, "alt");
                fl[0] = fl[0] + 1;
            end else begin
                cyc(4'b0100, 1'b0, "alt");
                fl[2] = fl[2] + 1;
            end
        end
        req = 4'b0000;
        cyc(4'b0000, 1'b0, "alt idle");

        // rrPtr now 3: all requesting, grants wrap 3,0,1,2
        req = 4'b1111;
        vc  = 4'b0101;
        ord[0] = 4'b1000;
        ord[1] = 4'b0001;
        ord[2] = 4'b0010;
        ord[3] = 4'b0100;
        for (int unsigned i = 0; i < 4; i++) begin
            cyc(ord[i], 1'b0, "wrap");
            req = req & ~ord[i];
        end

        // One packet from requester 0 moves rrPtr to 1
        req   = 4'b0001;
        vc[0] = 1'b0;
        cyc(4'b0001, 1'b0, "rr1");
        fl[0] = fl[0] + 1;
        req = 4'b0000;
        cyc(4'b0000, 1'b0, "gap");

        // 3-flit packet from requester 1 on VC0 while requester 3 waits
        req     = 4'b1010;
        vc[1]   = 1'b0;
        vc[3]   = 1'b1;
        tail[1] = 1'b0;
        tail[3] = 1'b1;
        cyc(4'b0010, 1'b0, "pkt t");
        fl[1] = fl[1] + 1;
        cyc(4'b0000, 1'b1, "pkt t+1");
        cyc(4'b0010, 1'b1, "pkt t+2");
        fl[1] = fl[1] + 1;
        tail[1] = 1'b1;
        cyc(4'b0000, 1'b1, "pkt t+3");
        cyc(4'b0010, 1'b1, "pkt t+4");
        req[1] = 1'b0;
        cyc(4'b1000, 1'b0, "pkt t+5");
        req[3] = 1'b0;

        // Both VCs full: no accept for 5 cycles
        nonFull = 2'b00;
        req     = 4'b1111;
        for (int unsigned i = 0; i < 5; i++) begin
            cyc(4'b0000, 1'b0, "full");
        end

        // Reset in the middle of a packet
        nonFull = 2'b11;
        req     = 4'b0100;
        vc      = 4'b0000;
        tail    = 4'b0000;
        fl[2]   = 32'h2200_0000;
        cyc(4'b0100, 1'b0, "lock");
        chk("lock busy_o", 64'(busy), 64'd1);
        #1;
        res = 1'b1;
        #1;
        chk("async busy_o", 64'(busy), 64'd0);
        chk("async en_put", 64'(enPut), 64'd0);
        chk("async ack_o", 64'(ack), 64'd0);
        chk("async put_flit", 64'(putFlit), 64'd0);
        chk("async en_get", 64'(enGet), 64'd0);
        lastFlit = '0;
`ifdef NOC_INJECT_STALL_CNT_EN
        expStall = 0;
`endif
        @(posedge clk);
        #1;
        res = 1'b0;
        chk("release en_put", 64'(enPut), 64'd0);
        chk("release busy_o", 64'(busy), 64'd0);
        req   = 4'b1110;
        vc    = 4'b0010;
        tail  = 4'b1111;
        fl[1] = 32'h3100_0000;
        fl[3] = 32'h3300_0000;
        cyc(4'b0010, 1'b0, "post rst");
        req = 4'b0000;
        cyc(4'b0000, 1'b0, "end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/noc_inject_arbiter.md
NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one NoC send port (2..8).
REQ-002 SHALL have parameter FLIT_W, default 32: flit width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port res  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_i  input  N_REQ  per-requester flit-valid.
REQ-006 SHALL have port flit_i  input  N_REQ*FLIT_W  per-requester flit; requester k at bits [k*FLIT_W +: FLIT_W].
REQ-007 SHALL have port tail_i  input  N_REQ  flit is last of packet.
REQ-008 SHALL have port vc_i  input  N_REQ  target VC index (0/1) of the flit.
REQ-009 SHALL have port ack_o  output  N_REQ  one-hot, combinational; flit accepted this cycle.
REQ-010 SHALL have port put_flit  output  FLIT_W  flit to NoC send port.
REQ-011 SHALL have port en_put  output  1  put enable to NoC send port.
REQ-012 SHALL have port en_get_non_full_VCs  output  1  read enable for VC status.
REQ-013 SHALL have port get_non_full_VCs  input  2  per-VC non-full flags from NoC.
REQ-014 SHALL have port busy_o  output  1  packet lock held.

Function
REQ-015 Requester SHALL hold req/flit/tail/vc stable from assertion until ack; block need not tolerate violation.
REQ-016 Requester k SHALL be eligible when req_i[k]=1, get_non_full_VCs[vc_i[k]]=1, and no put to VC vc_i[k] is in the output register (not (en_put=1 and vc_q=vc_i[k])).
REQ-017 Eligibility rule SHALL limit each VC to one flit per 2 cycles; alternating VCs SHALL sustain 1 flit/cycle.
REQ-018 FSM states SHALL be IDLE and LOCKED; reset state IDLE.
REQ-019 In IDLE, winner SHALL be first eligible requester scanning from rr_ptr upward, modulo N_REQ; ack_o[winner]=1 same cycle.
REQ-020 In IDLE, accepted flit with tail=0 SHALL go to LOCKED, lock_id=winner; with tail=1, stay IDLE.
REQ-021 In LOCKED, only lock_id SHALL be considered; ack_o[lock_id]=1 when eligible; all other acks 0.
REQ-022 In LOCKED, accepted flit with tail=1 SHALL return to IDLE.
REQ-023 rr_ptr SHALL update to (winner+1) mod N_REQ only on accepting a tail flit; wrap from N_REQ-1 to 0.
REQ-024 Accepted flit SHALL be registered: put_flit=flit, en_put=1, vc_q=vc in the cycle after ack (latency 1).
REQ-025 When no ack, en_put SHALL be 0 next cycle and put_flit SHALL hold its last value.
REQ-026 en_get_non_full_VCs SHALL be 1 every cycle while res=0.
REQ-027 busy_o SHALL be 1 exactly when state is LOCKED.
REQ-028 ack_o SHALL be one-hot or zero in every cycle; all zero while res=1.
REQ-029 Both VCs full SHALL stall with no ack and no state change; lock SHALL be held.

Reset
REQ-030 res=1 SHALL immediately force state IDLE, rr_ptr=0, lock_id=0, en_put=0, put_flit=0, vc_q=0, busy_o=0.
REQ-031 Reset mid-packet SHALL drop the lock; no flit SHALL be emitted for the cycle after reset release unless acked after release.

Configuration
REQ-032 Macro NOC_INJECT_STALL_CNT_EN, when defined, SHALL add output stall_cnt_o (16 bits): cycles with any req_i=1 and ack_o=0, saturating at 0xFFFF, reset to 0.
REQ-033 Without NOC_INJECT_STALL_CNT_EN, port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-034 Requesters 0 and 2 each send 1-flit packets, VC0 and VC1, non_full=2'b11 -> acks 0,2,0,2 on consecutive cycles, en_put=1 every cycle from cycle after first ack.
REQ-035 Requester 1 sends 3-flit packet on VC0 while requester 3 requests -> acks to 1 at t, t+2, t+4 (VC0 gap), requester 3 acked only after tail, busy_o=1 from t+1 to t+4.
REQ-036 non_full=2'b00 for 5 cycles with req_i=4'b1111 -> no ack, en_put=0; with macro, stall_cnt_o increments by 5.
REQ-037 rr_ptr=3, all requesters eligible with tail=1 -> grant order 3,0,1,2 (wrap-around).
REQ-038 res asserted during LOCKED mid-packet -> en_put=0, busy_o=0 asynchronously; after release, lowest eligible index from 0 wins.
